// File: rtl/plru_tree_bank_pkg.sv
// Shared types and helpers for the multi-set tree pseudo-LRU bank.
// The helpers work on vectors padded to the widest supported tree (64 ways).
// Callers zero-extend their narrower state and pass the real level count,
// so the same functions serve every WAYS setting.
package plru_pkg;

  localparam int MAX_WAYS  = 64;
  localparam int MAX_WAY_W = 6;

  typedef logic [MAX_WAYS-2:0]  tree_t;
  typedef logic [MAX_WAYS-1:0]  valid_t;
  typedef logic [MAX_WAY_W-1:0] way_t;

  typedef enum logic {
    IDLE,
    SWEEP
  } flush_state_e;

  typedef struct packed {
    logic any;
    way_t way;
  } inv_pick_t;

  // Walk the path of 'way' from its MSB down.
  // Every node on the path is made to point away from the accessed way.
  function automatic tree_t tree_update(input tree_t tree, input way_t way, input int levels);
    tree_t      t;
    logic [5:0] node;
    way_t       sh;
    logic       dir;
    t    = tree;
    node = '0;
    for (int l = MAX_WAY_W - 1; l >= 0; l--) begin
      if (l < levels) begin
        sh      = way >> l;
        dir     = sh[0];
        t[node] = ~dir;
        node    = (node << 1) + 6'd1 + {5'd0, dir};
      end
    end
    return t;
  endfunction

  // Follow the node bits from the root; the bits taken spell the way, MSB first.
  function automatic way_t tree_victim(input tree_t tree, input int levels);
    way_t       v;
    logic [5:0] node;
    logic       dir;
    v    = '0;
    node = '0;
    for (int l = MAX_WAY_W - 1; l >= 0; l--) begin
      if (l < levels) begin
        dir  = tree[node];
        v    = {v[MAX_WAY_W-2:0], dir};
        node = (node << 1) + 6'd1 + {5'd0, dir};
      end
    end
    return v;
  endfunction

  // Lowest-index invalid way among the first 'ways' entries.
  // The scan runs from the top down so the lowest hit is the one that sticks.
  function automatic inv_pick_t first_invalid(input valid_t valid, input int ways);
    inv_pick_t r;
    valid_t    sh;
    r.any = 1'b0;
    r.way = '0;
    for (int i = MAX_WAYS - 1; i >= 0; i--) begin
      sh = valid >> i;
      if (i < ways && !sh[0]) begin
        r.any = 1'b1;
        r.way = way_t'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/plru_tree_bank_if.sv
// Controller-side bundle of the PLRU bank: update, invalidate, flush and
// the victim query handshake. The cache controller is the master.
interface plru_tree_bank_if #(
  parameter int WAYS = 4,
  parameter int SETS = 64
);

  localparam int WAY_W = $clog2(WAYS);
  localparam int SET_W = $clog2(SETS);

  logic             upd_en;
  logic [SET_W-1:0] upd_set;
  logic [WAY_W-1:0] upd_way;
  logic             inv_en;
  logic [SET_W-1:0] inv_set;
  logic [WAY_W-1:0] inv_way;
  logic             flush;
  logic             busy;
  logic             vic_req;
  logic [SET_W-1:0] vic_set;
  logic             vic_valid;
  logic [WAY_W-1:0] vic_way;

  modport master (
    output upd_en, upd_set, upd_way,
    output inv_en, inv_set, inv_way,
    output flush, vic_req, vic_set,
    input  busy, vic_valid, vic_way
  );

  modport slave (
    input  upd_en, upd_set, upd_way,
    input  inv_en, inv_set, inv_way,
    input  flush, vic_req, vic_set,
    output busy, vic_valid, vic_way
  );

endinterface

// File: rtl/plru_tree_bank_node_logic.sv
// Combinational PLRU logic for a single set.
// Produces the tree after an access to 'way' and the victim that the
// current state selects. Invalid ways take priority over the tree.
module plru_tree_node_logic
  import plru_pkg::*;
#(
  parameter int WAYS  = 4,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-2:0]  tree,
  input  logic [WAYS-1:0]  valid,
  input  logic [WAY_W-1:0] way,
  output logic [WAYS-2:0]  tree_next,
  output logic [WAY_W-1:0] victim
);

  // The helpers return padded vectors; only the low WAYS-related bits matter.
  tree_t     tree_wide_unused;
  way_t      victim_wide_unused;
  inv_pick_t pick_wide_unused;

  // Evaluate the shared helpers on zero-extended state and trim the results.
  always_comb begin
    tree_wide_unused   = tree_update(tree_t'(tree), way_t'(way), WAY_W);
    victim_wide_unused = tree_victim(tree_t'(tree), WAY_W);
    pick_wide_unused   = first_invalid(valid_t'(valid), WAYS);
    tree_next          = tree_wide_unused[WAYS-2:0];
    victim             = pick_wide_unused.any ? pick_wide_unused.way[WAY_W-1:0]
                                              : victim_wide_unused[WAY_W-1:0];
  end

endmodule

// File: rtl/plru_tree_bank.sv
// Multi-set, N-way tree pseudo-LRU bank.
// Holds tree and valid bits for every set, applies hit/fill updates and
// invalidates, answers victim queries one cycle later (read-before-write),
// and clears all sets with a one-set-per-cycle flush sweep.
module plru_tree_bank
  import plru_pkg::*;
#(
  parameter int WAYS = 4,
  parameter int SETS = 64
) (
  input logic               clk,
  input logic               rst_n,
  plru_tree_bank_if.slave   bus
);

  localparam int WAY_W = $clog2(WAYS);
  localparam int SET_W = $clog2(SETS);

  logic [WAYS-2:0]  tree_q  [SETS];
  logic [WAYS-1:0]  valid_q [SETS];

  flush_state_e     state;
  logic [SET_W-1:0] sweep_cnt;
  logic             vic_valid_q;
  logic [WAY_W-1:0] vic_way_q;

  logic [WAYS-2:0]  upd_tree_next;
  logic [WAY_W-1:0] upd_victim_unused;
  logic [WAYS-2:0]  vic_tree_next_unused;
  logic [WAY_W-1:0] vic_pick;

  // Next-tree computation for the set being updated.
  plru_tree_node_logic #(.WAYS(WAYS)) u_upd_logic (
    .tree      (tree_q[bus.upd_set]),
    .valid     (valid_q[bus.upd_set]),
    .way       (bus.upd_way),
    .tree_next (upd_tree_next),
    .victim    (upd_victim_unused)
  );

  // Victim selection for the set being queried, from pre-update state.
  plru_tree_node_logic #(.WAYS(WAYS)) u_vic_logic (
    .tree      (tree_q[bus.vic_set]),
    .valid     (valid_q[bus.vic_set]),
    .way       ({WAY_W{1'b0}}),
    .tree_next (vic_tree_next_unused),
    .victim    (vic_pick)
  );

  // Flush FSM plus all state updates; nothing but the sweep runs while busy,
  // and a flush request masks any access presented alongside it.
  // Update is written after invalidate so it wins on the same valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sweep_cnt   <= '0;
      tree_q      <= '{default: '0};
      valid_q     <= '{default: '0};
      vic_valid_q <= 1'b0;
      vic_way_q   <= '0;
    end else begin
      vic_valid_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.flush) begin
            state     <= SWEEP;
            sweep_cnt <= '0;
          end else begin
            if (bus.vic_req) begin
              vic_valid_q <= 1'b1;
              vic_way_q   <= vic_pick;
            end
            if (bus.inv_en) begin
              valid_q[bus.inv_set][bus.inv_way] <= 1'b0;
            end
            if (bus.upd_en) begin
              tree_q[bus.upd_set]               <= upd_tree_next;
              valid_q[bus.upd_set][bus.upd_way] <= 1'b1;
            end
          end
        end
        SWEEP: begin
          tree_q[sweep_cnt]  <= '0;
          valid_q[sweep_cnt] <= '0;
          sweep_cnt          <= sweep_cnt + SET_W'(1);
          if (sweep_cnt == '1) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = (state == SWEEP);
  assign bus.vic_valid = vic_valid_q;
  assign bus.vic_way   = vic_way_q;

endmodule
